wb64_pipelined_slave_mem: RTL and testbench
===========================================

// Module: wb64_pipelined_slave_mem
// PURPOSE
//  Synthesizable pipelined Wishbone B4 64-bit slave (responder) backed by on-chip RAM.
//  Completing end for the 64-bit WB master port on the DDR side.
//  Serves as scratch memory and as a DDR stand-in for simulation builds.
//  Fixed, parameterised ack latency, with outstanding-request limiting via stall_o.
// PARAMETERS
//  g_ADDR_WIDTH      10  log2 of RAM depth in 64-bit words
//  g_LATENCY         4   cycles from request acceptance to ack/err (1..16)
//  g_MAX_OUTSTANDING 4   accepted but un-acked requests allowed (1..g_LATENCY)
// PORTS
//  clk_i     in   1   sole clock
//  rst_n_i   in   1   reset, synchronous, active-low
//  wb_cyc_i  in   1   bus cycle
//  wb_stb_i  in   1   strobe
//  wb_we_i   in   1   1=write
//  wb_adr_i  in   32  byte address; word index = adr[g_ADDR_WIDTH+2:3]
//  wb_sel_i  in   8   byte lane enables, bit n -> dat[8n+7:8n]
//  wb_dat_i  in   64  write data
//  wb_dat_o  out  64  read data, valid only with ack
//  wb_ack_o  out  1   one pulse per accepted request
//  wb_err_o  out  1   error termination (see CONFIGURATION)
//  wb_stall_o out 1   request not accepted this cycle
// BEHAVIOUR
//  Reset: ack=0, err=0, stall=0, dat_o=0, outstanding=0, pipeline cleared; RAM contents kept.
//  Acceptance: accept = cyc & stb & ~stall_o.
//  Access at acceptance:
//   - Write updates only lanes with sel=1.
//   - Read samples the RAM word.
//  Response pipeline: accepted op enters a g_LATENCY-deep shift pipeline {valid,err,data}.
//   - ack/err are registered outputs from the last stage: first ack exactly g_LATENCY
//     cycles after the accept edge.
//   - Responses are returned in order.
//   - Back-to-back accepts give back-to-back acks.
//  Outstanding counter:
//   - +1 on accept, -1 on ack/err.
//   - Same-cycle accept and ack leave it unchanged.
//   - stall_o = (outstanding == g_MAX_OUTSTANDING) & ~(ack|err leaving this cycle),
//     registered, so stall_o is combinational-free.
//  Write-then-read of the same word in consecutive accepts: the read returns the new data.
//  FSM:
//   - IDLE: cyc=0, outstanding=0. cyc=1 -> ACTIVE.
//   - ACTIVE: accepting. cyc falls with outstanding>0 -> ABORT; with outstanding=0 -> IDLE.
//   - ABORT: one cycle; clear pipeline valids and outstanding, no ack/err emitted -> IDLE.
//  Abort rules:
//   - Writes already accepted stay committed.
//   - stall_o=1 during ABORT.
//  Responses for an aborted cycle never leak into the next cycle.
//  cyc=1, stb=0: no accept; pipeline continues draining.
//  Synchronous reset mid-burst: pipeline dropped, no further ack, next cycle IDLE.
//  RAM write enable is gated by reset.
// CONFIGURATION
//  Macro: WB64_SLAVE_ERR_EN
//  - Defined: any wb_adr_i bit above g_ADDR_WIDTH+2 set -> request terminates with err_o
//    instead of ack_o at the same latency; write suppressed; dat_o=0.
//  - Undefined: upper address bits ignored (access wraps into RAM); wb_err_o tied 0.
// STRUCTURE
//  Package wb64_slave_pkg:
//   - t_wb64_rsp struct {valid, err, dat[63:0]}
//   - t_wb64_state enum {ST_IDLE, ST_ACTIVE, ST_ABORT}
//   - c_WB64_SEL_W=8
//   - function f_word_idx
//  Sub-module wb64_byte_ram: single-port 2^g_ADDR_WIDTH x 64 RAM with 8 byte write-enables,
//  read-during-write returns new data.
//  The top level holds the FSM, outstanding counter and response pipeline.
// TESTING
//  1 Single write 0x1122334455667788 @0x0, sel=0xFF, then read @0x0
//    -> ack 4 cycles after each accept; read dat=0x1122334455667788.
//  2 Write sel=0x0F data 0xAAAAAAAA_BBBBBBBB over 0x1122334455667788 @0x8
//    -> read 0x11223344_BBBBBBBB.
//  3 Burst of 8 reads, stb held high, g_MAX_OUTSTANDING=4
//    -> stall_o high after the 4th accept, then 1 accept per ack; 8 acks, in order.
//  4 Drop cyc with 3 outstanding -> zero acks afterwards, stall_o=1 for 1 cycle,
//    next cycle's first read ack after exactly 4 cycles.
//  5 WB64_SLAVE_ERR_EN, write @0x0010_0000 (g_ADDR_WIDTH=10) -> err_o pulse at latency 4,
//    no ack, word 0 unchanged. Without the macro: ack, write lands in word 0.
//  6 rst_n_i low 1 cycle mid-burst -> ack/err/stall=0 next cycle, outstanding=0,
//    RAM data written before reset still readable.

Source files
------------

// File: rtl/wb64_slave_pkg.sv
// Shared types, widths and address helpers for the 64-bit Wishbone RAM slave.
package wb64_slave_pkg;

    localparam int c_WB64_SEL_W = 8;
    localparam int c_WB64_DAT_W = 64;
    localparam int c_WB64_CNT_W = 5;

    typedef struct packed {
        logic                    valid;
        logic                    err;
        logic [c_WB64_DAT_W-1:0] dat;
    } t_wb64_rsp;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_ABORT
    } t_wb64_state;

    // Byte address to 64-bit word index, masked to the RAM depth.
    function automatic logic [31:0] f_word_idx(input logic [31:0] adr, input int aw);
        return (adr >> 3) & ((32'd1 << aw) - 32'd1);
    endfunction

    function automatic logic f_addr_oor(input logic [31:0] adr, input int aw);
        return (adr >> (aw + 3)) != 32'd0;
    endfunction

endpackage

// File: rtl/wb64_byte_ram.sv
// Single-port 2^g_ADDR_WIDTH x 64 RAM with per-byte write enables and
// registered read that returns the newly written data on read-during-write.
module wb64_byte_ram
    import wb64_slave_pkg::*;
#(
    parameter int g_ADDR_WIDTH = 10
) (
    input  logic                    clk_i,
    input  logic                    en_i,
    input  logic [c_WB64_SEL_W-1:0] we_i,
    input  logic [g_ADDR_WIDTH-1:0] addr_i,
    input  logic [c_WB64_DAT_W-1:0] wdata_i,
    output logic [c_WB64_DAT_W-1:0] rdata_o
);

    logic [c_WB64_DAT_W-1:0] mem_q [2**g_ADDR_WIDTH];
    logic [c_WB64_DAT_W-1:0] merged;
    logic [c_WB64_DAT_W-1:0] rdata_d;
    logic [c_WB64_DAT_W-1:0] rdata_q;

    always_comb begin
        merged = mem_q[addr_i];
        for (int b = 0; b < c_WB64_SEL_W; b++) begin
            if (we_i[b]) merged[8*b +: 8] = wdata_i[8*b +: 8];
        end
        rdata_d = en_i ? merged : rdata_q;
    end

    // NOTE: the array and read register carry no reset so the RAM maps onto block memory.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < c_WB64_SEL_W; b++) begin
            if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
        rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/wb64_pipelined_slave_mem.sv
// Pipelined Wishbone B4 64-bit slave over on-chip RAM with fixed ack latency.
// Macro WB64_SLAVE_ERR_EN: addresses beyond the RAM terminate with err instead of ack.
module wb64_pipelined_slave_mem
    import wb64_slave_pkg::*;
#(
    parameter int g_ADDR_WIDTH      = 10,
    parameter int g_LATENCY         = 4,
    parameter int g_MAX_OUTSTANDING = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [7:0]  wb_sel_i,
    input  logic [63:0] wb_dat_i,
    output logic [63:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_stall_o
);

    localparam int c_LAST = g_LATENCY - 1;

    t_wb64_state             state_q, state_d;
    t_wb64_rsp               pipe_q [g_LATENCY];
    t_wb64_rsp               pipe_d [g_LATENCY];
    logic                    req_vld_q, req_vld_d;
    logic                    req_err_q, req_err_d;
    logic [c_WB64_CNT_W-1:0] outstanding_q, outstanding_d;
    logic                    stall_q, stall_d;

    logic                    accept;
    logic                    req_err;
    logic                    flush;
    logic [g_ADDR_WIDTH-1:0] word_idx;
    logic [c_WB64_SEL_W-1:0] ram_we;
    logic [c_WB64_DAT_W-1:0] ram_rdata;

    assign accept = rst_n_i & wb_cyc_i & wb_stb_i & ~stall_q;

`ifdef WB64_SLAVE_ERR_EN
    assign req_err = f_addr_oor(wb_adr_i, g_ADDR_WIDTH);
`else
    assign req_err = 1'b0;
`endif

    assign word_idx = g_ADDR_WIDTH'(f_word_idx(wb_adr_i, g_ADDR_WIDTH));
    // Lane enables already fold in reset, range error and direction.
    assign ram_we   = (accept & wb_we_i & ~req_err) ? wb_sel_i : '0;

    wb64_byte_ram #(
        .g_ADDR_WIDTH(g_ADDR_WIDTH)
    ) u_ram (
        .clk_i  (clk_i),
        .en_i   (accept),
        .we_i   (ram_we),
        .addr_i (word_idx),
        .wdata_i(wb_dat_i),
        .rdata_o(ram_rdata)
    );

    // NOTE: every output of this block gets a default first so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (wb_cyc_i) state_d = ST_ACTIVE;
            ST_ACTIVE: if (!wb_cyc_i) state_d = (outstanding_q != '0) ? ST_ABORT : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        flush     = (state_d == ST_ABORT);
        req_vld_d = accept;
        req_err_d = accept & req_err;

        // RAM read data arrives one cycle after acceptance, so it joins at stage 0.
        pipe_d[0].valid = req_vld_q;
        pipe_d[0].err   = req_err_q;
        pipe_d[0].dat   = (req_vld_q & ~req_err_q) ? ram_rdata : '0;
        for (int i = 1; i < g_LATENCY; i++) pipe_d[i] = pipe_q[i-1];

        outstanding_d = outstanding_q + c_WB64_CNT_W'(accept)
                      - c_WB64_CNT_W'(pipe_q[c_LAST].valid);

        if (flush) begin
            req_vld_d = 1'b0;
            req_err_d = 1'b0;
            for (int i = 0; i < g_LATENCY; i++) begin
                pipe_d[i].valid = 1'b0;
                pipe_d[i].err   = 1'b0;
            end
            outstanding_d = '0;
        end

        stall_d = flush | ((outstanding_d == c_WB64_CNT_W'(g_MAX_OUTSTANDING))
                           & ~pipe_d[c_LAST].valid);
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_IDLE;
            req_vld_q     <= 1'b0;
            req_err_q     <= 1'b0;
            outstanding_q <= '0;
            stall_q       <= 1'b0;
            for (int i = 0; i < g_LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            req_vld_q     <= req_vld_d;
            req_err_q     <= req_err_d;
            outstanding_q <= outstanding_d;
            stall_q       <= stall_d;
            pipe_q        <= pipe_d;
        end
    end

    assign wb_ack_o   = pipe_q[c_LAST].valid & ~pipe_q[c_LAST].err;
    assign wb_dat_o   = pipe_q[c_LAST].dat;
    assign wb_stall_o = stall_q;

`ifdef WB64_SLAVE_ERR_EN
    assign wb_err_o = pipe_q[c_LAST].valid & pipe_q[c_LAST].err;
`else
    assign wb_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb64_pipelined_slave_mem.sv
// Self-checking bench for wb64_pipelined_slave_mem: scoreboard of in-order fixed-latency
// responses against an array memory model; honours WB64_SLAVE_ERR_EN when defined.
module tb_wb64_pipelined_slave_mem;

    localparam int L   = 4;
    localparam int MAX = 4;
    localparam int AW  = 10;
`ifdef WB64_SLAVE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_adr;
    logic [7:0]  wb_sel;
    logic [63:0] wb_dat;
    logic [63:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o, wb_stall_o;

    always #5 clk = ~clk;

    wb64_pipelined_slave_mem #(
        .g_ADDR_WIDTH(AW), .g_LATENCY(L), .g_MAX_OUTSTANDING(MAX)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb),
        .wb_we_i(wb_we), .wb_adr_i(wb_adr), .wb_sel_i(wb_sel), .wb_dat_i(wb_dat),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .wb_stall_o(wb_stall_o)
    );

    typedef struct {
        int          due;
        bit          err;
        bit          rd;
        logic [63:0] dat;
    } exp_t;

    exp_t        q[$];
    logic [63:0] mem_model [2**AW];
    int          checks = 0, failures = 0;
    int          cyc_cnt = 0, ack_cnt = 0, err_cnt = 0;
    int          last_acc_cyc = 0, last_ack_cyc = 0;
    bit          last_acc = 1'b0, rsp_vis = 1'b0;
    logic [63:0] last_rd_dat = '0;

    // One clock: model the acceptance, advance, then score the sampled outputs.
    task automatic step();
        bit   acc, abort_now, exp_rsp, exp_stall, exp_ack;
        exp_t e;
        int   word;
        acc       = (rst_n === 1'b1) && (wb_cyc === 1'b1) && (wb_stb === 1'b1) && (wb_stall_o === 1'b0);
        abort_now = (rst_n === 1'b1) && (wb_cyc === 1'b0) && (q.size() != 0 || rsp_vis);
        if (acc) begin
            word  = int'((wb_adr >> 3) % (2**AW));
            e.due = cyc_cnt + 1 + L;
            e.err = ERR_EN && ((wb_adr >> (AW + 3)) != 0);
            e.rd  = !wb_we;
            e.dat = '0;
            if (wb_we && !e.err) begin
                for (int b = 0; b < 8; b++)
                    if (wb_sel[b]) mem_model[word][8*b +: 8] = wb_dat[8*b +: 8];
            end
            if (!wb_we && !e.err) e.dat = mem_model[word];
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc_cnt++;
        last_acc = acc;
        if (acc) last_acc_cyc = cyc_cnt;
        if (rst_n !== 1'b1 || abort_now) q.delete();

        exp_rsp   = (q.size() != 0) && (q[0].due == cyc_cnt);
        exp_stall = abort_now || (q.size() == MAX && !exp_rsp);
        checks++;
        if (wb_stall_o !== exp_stall) begin
            failures++;
            $display("FAIL stall cycle=%0d got=%b exp=%b", cyc_cnt, wb_stall_o, exp_stall);
        end
        if (wb_ack_o === 1'b1) ack_cnt++;
        if (wb_err_o === 1'b1) err_cnt++;
        if (wb_ack_o === 1'b1 || wb_err_o === 1'b1) last_ack_cyc = cyc_cnt;
        if (exp_rsp) begin
            e       = q.pop_front();
            exp_ack = !e.err;
            checks++;
            if (wb_ack_o !== exp_ack || wb_err_o !== e.err) begin
                failures++;
                $display("FAIL response cycle=%0d got ack=%b err=%b exp ack=%b err=%b",
                         cyc_cnt, wb_ack_o, wb_err_o, exp_ack, e.err);
            end
            if (e.rd || e.err) begin
                checks++;
                if (wb_dat_o !== e.dat) begin
                    failures++;
                    $display("FAIL read_data cycle=%0d got=%h exp=%h", cyc_cnt, wb_dat_o, e.dat);
                end
            end
            if (e.rd) last_rd_dat = wb_dat_o;
        end else begin
            checks++;
            if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0) begin
                failures++;
                $display("FAIL spurious_response cycle=%0d got ack=%b err=%b exp none",
                         cyc_cnt, wb_ack_o, wb_err_o);
            end
        end
        rsp_vis = exp_rsp;
    endtask

    task automatic issue(input bit we, input logic [31:0] adr, input logic [7:0] sel,
                         input logic [63:0] dat);
        int guard = 0;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
        wb_adr = adr;  wb_sel = sel;  wb_dat = dat;
        do begin
            step();
            guard++;
        end while (!last_acc && guard < 32);
        wb_stb = 1'b0;
        checks++;
        if (!last_acc) begin
            failures++;
            $display("FAIL accept_timeout adr=%h got no accept exp accept within 32 cycles", adr);
        end
    endtask

    task automatic drain();
        int guard = 0;
        while ((q.size() != 0 || rsp_vis) && guard < 64) begin
            step();
            guard++;
        end
        checks++;
        if (guard >= 64) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d exp 0", q.size());
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;
        step();
    endtask

    task automatic test_reset();
        checks++;
        if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0 || wb_stall_o !== 1'b0 || wb_dat_o !== 64'h0) begin
            failures++;
            $display("FAIL reset_state got ack=%b err=%b stall=%b dat=%h exp all zero",
                     wb_ack_o, wb_err_o, wb_stall_o, wb_dat_o);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_write_read();
        int acc_at;
        issue(1'b1, 32'h0, 8'hFF, 64'h1122334455667788);
        issue(1'b0, 32'h0, 8'hFF, 64'h0);
        acc_at = last_acc_cyc;
        drain();
        checks++;
        if (last_rd_dat !== 64'h1122334455667788) begin
            failures++;
            $display("FAIL single_read got=%h exp=%h", last_rd_dat, 64'h1122334455667788);
        end
        checks++;
        if (last_ack_cyc - acc_at != L) begin
            failures++;
            $display("FAIL read_latency got=%0d exp=%0d", last_ack_cyc - acc_at, L);
        end
    endtask

    task automatic test_byte_lanes();
        issue(1'b1, 32'h8, 8'hFF, 64'h1122334455667788);
        issue(1'b1, 32'h8, 8'h0F, 64'hAAAAAAAA_BBBBBBBB);
        issue(1'b0, 32'h8, 8'hFF, 64'h0);
        drain();
        checks++;
        if (last_rd_dat !== 64'h11223344_BBBBBBBB) begin
            failures++;
            $display("FAIL byte_lanes got=%h exp=%h", last_rd_dat, 64'h11223344_BBBBBBBB);
        end
    endtask

    task automatic test_fill();
        for (int w = 0; w < 32; w++)
            issue(1'b1, 32'(w) << 3, 8'hFF, {$urandom, $urandom});
        drain();
    endtask

    task automatic test_burst();
        int  acc_n = 0, guard = 0, a0;
        a0 = ack_cnt;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 8'hFF;
        while (acc_n < 8 && guard < 100) begin
            wb_adr = 32'(acc_n) << 3;
            step();
            guard++;
            if (last_acc) begin
                acc_n++;
                if (acc_n == MAX) begin
                    checks++;
                    if (wb_stall_o !== 1'b1) begin
                        failures++;
                        $display("FAIL burst_stall got=%b exp=1", wb_stall_o);
                    end
                end
            end
        end
        wb_stb = 1'b0;
        drain();
        checks++;
        if (ack_cnt - a0 != 8) begin
            failures++;
            $display("FAIL burst_acks got=%0d exp=8", ack_cnt - a0);
        end
    endtask

    task automatic test_random();
        wb_cyc = 1'b1; wb_stb = 1'b0;
        repeat (300) begin
            if (!wb_stb || last_acc) begin
                wb_stb = ($urandom_range(0, 3) != 0);
                wb_we  = $urandom_range(0, 1) == 1;
                wb_adr = (32'($urandom_range(0, 31)) << 3) | 32'($urandom_range(0, 7));
                if ($urandom_range(0, 15) == 0) wb_adr = wb_adr | 32'h0010_0000;
                wb_sel = 8'($urandom);
                wb_dat = {$urandom, $urandom};
            end
            step();
        end
        wb_stb = 1'b0;
        drain();
    endtask

    task automatic test_abort();
        int a0, e0, acc_at;
        logic [63:0] wdat;
        wdat = {$urandom, $urandom};
        issue(1'b1, 32'(5) << 3, 8'hFF, wdat);
        issue(1'b0, 32'(6) << 3, 8'hFF, 64'h0);
        issue(1'b0, 32'(7) << 3, 8'hFF, 64'h0);
        a0 = ack_cnt; e0 = err_cnt;
        wb_cyc = 1'b0;
        step();
        checks++;
        if (wb_stall_o !== 1'b1) begin
            failures++;
            $display("FAIL abort_stall got=%b exp=1", wb_stall_o);
        end
        step();
        checks++;
        if (wb_stall_o !== 1'b0) begin
            failures++;
            $display("FAIL abort_stall_release got=%b exp=0", wb_stall_o);
        end
        repeat (8) step();
        checks++;
        if (ack_cnt != a0 || err_cnt != e0) begin
            failures++;
            $display("FAIL abort_leak got acks=%0d errs=%0d exp 0", ack_cnt - a0, err_cnt - e0);
        end
        issue(1'b0, 32'(5) << 3, 8'hFF, 64'h0);
        acc_at = last_acc_cyc;
        drain();
        checks++;
        if (last_ack_cyc - acc_at != L || last_rd_dat !== wdat) begin
            failures++;
            $display("FAIL post_abort_read got lat=%0d dat=%h exp lat=%0d dat=%h",
                     last_ack_cyc - acc_at, last_rd_dat, L, wdat);
        end
    endtask

    task automatic test_err();
        int a0, e0;
        logic [63:0] old0, wdat;
        old0 = mem_model[0];
        wdat = ~old0;
        a0 = ack_cnt; e0 = err_cnt;
        issue(1'b1, 32'h0010_0000, 8'hFF, wdat);
        drain();
        issue(1'b0, 32'h0, 8'hFF, 64'h0);
        drain();
        checks++;
`ifdef WB64_SLAVE_ERR_EN
        if (err_cnt - e0 != 1 || ack_cnt - a0 != 1 || last_rd_dat !== old0) begin
            failures++;
            $display("FAIL err_range got errs=%0d acks=%0d word0=%h exp errs=1 acks=1 word0=%h",
                     err_cnt - e0, ack_cnt - a0, last_rd_dat, old0);
        end
`else
        if (err_cnt - e0 != 0 || ack_cnt - a0 != 2 || last_rd_dat !== wdat) begin
            failures++;
            $display("FAIL addr_wrap got errs=%0d acks=%0d word0=%h exp errs=0 acks=2 word0=%h",
                     err_cnt - e0, ack_cnt - a0, last_rd_dat, wdat);
        end
`endif
    endtask

    task automatic test_reset_mid_burst();
        int a0;
        logic [63:0] wdat;
        wdat = {$urandom, $urandom};
        issue(1'b1, 32'(10) << 3, 8'hFF, wdat);
        issue(1'b0, 32'(11) << 3, 8'hFF, 64'h0);
        issue(1'b0, 32'(12) << 3, 8'hFF, 64'h0);
        rst_n = 1'b0;
        step();
        checks++;
        if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0 || wb_stall_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got ack=%b err=%b stall=%b exp all zero",
                     wb_ack_o, wb_err_o, wb_stall_o);
        end
        rst_n = 1'b1; wb_cyc = 1'b0;
        a0 = ack_cnt;
        repeat (6) step();
        checks++;
        if (ack_cnt != a0) begin
            failures++;
            $display("FAIL reset_leak got acks=%0d exp 0", ack_cnt - a0);
        end
        issue(1'b0, 32'(10) << 3, 8'hFF, 64'h0);
        drain();
        checks++;
        if (last_rd_dat !== wdat) begin
            failures++;
            $display("FAIL ram_kept got=%h exp=%h", last_rd_dat, wdat);
        end
    endtask

    initial begin
        rst_n = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        wb_adr = '0; wb_sel = '0; wb_dat = '0;
        repeat (3) step();
        test_reset();
        test_single_write_read();
        test_byte_lanes();
        test_fill();
        test_burst();
        test_random();
        test_abort();
        test_err();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
